odbiornik_uart: RTL and testbench
=================================

Name: odbiornik_uart

Overview:
UART receiver, 8N1 format, LSB first. Oversamples the asynchronous serial line `RXD_i` with the system clock. Each bit is sampled at its midpoint. On a valid stop bit it presents the byte on `rxData_o` and emits a one-cycle strobe. Sits at the RS-232 input of the design; default timing is 100 MHz clock, 9600 baud.

Parameters:
- CLKS_PER_BIT, default 10416: system clock cycles per bit period (100 MHz / 9600 baud).
- HALF_BIT, default CLKS_PER_BIT/2 (5208): offset from the start-bit edge to the start-bit midpoint.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- RXD_i  input  1  serial line; idles high.
- rxODEBRANE  output  1  "byte received" strobe; high for exactly one clk_i cycle.
- rxData_o  output  8  last correctly received byte.

Behaviour:
- Clocking/reset: one clock (`clk_i`). Reset is synchronous and active-high (`rst_i`).
- Reset values:
  - state = IDLE; counters = 0; shift register = 0.
  - `rxODEBRANE` = 0; `rxData_o` = 8'h00.
  - Synchronizer flops = 1.
- Power-up: all registers also carry these values as initial values, so the block works without reset being asserted.
- Input synchronizer: `RXD_i` passes through 2 flip-flops before use. All decisions use the synchronized value `rxd_s`.
- Counters:
  - Bit-timer counts 0..CLKS_PER_BIT-1.
  - Bit index counts 0..7 (3 bits).
- IDLE:
  - Timer held at 0.
  - `rxd_s` == 0 → START, timer cleared.
- START:
  - Timer increments each cycle.
  - At timer == HALF_BIT-1, test `rxd_s`: if 0, go to DATA with timer and bit index cleared; if 1, treat as a glitch and go back to IDLE with no output change.
- DATA:
  - At timer == CLKS_PER_BIT-1 (one bit period after the previous sample point), shift `rxd_s` into the MSB of the shift register (right shift, so the first bit lands in bit 0 after 8 shifts), then clear the timer.
  - After the 8th sample (index 7), go to STOP.
- STOP:
  - At timer == CLKS_PER_BIT-1, sample `rxd_s`.
  - If 1: load `rxData_o` with the shift register, pulse `rxODEBRANE` for that cycle only, go to IDLE.
  - If 0 (framing error): no strobe, `rxData_o` unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rxd_s` == 1, then IDLE. This prevents a broken frame or break condition from being re-read as a start bit.
- Latency: strobe asserted about 9.5 × CLKS_PER_BIT + 3 cycles after the falling edge of the start bit on `RXD_i`.
- Back-to-back frames: a minimum of one stop bit is supported. A new start edge is detected in IDLE right after the stop-bit sample, i.e. half a bit before the stop bit ends.
- Holding: `rxData_o` holds its value until the next valid frame completes. `rxODEBRANE` is 0 except in the completion cycle.
- Start-bit tolerance: start bits longer than one period (e.g. +500 ns) still decode correctly, because all samples are referenced to the falling edge.
- Reset mid-frame: the frame is abandoned immediately, outputs return to reset values, and no strobe is produced.

Optional Feature:
- Macro: ODBIORNIK_FRAME_ERR_EN.
- When defined: adds output port `rxFrameErr_o` (1 bit, reset 0). It is high for exactly one cycle when a STOP sample reads 0; in every other respect behaviour is identical.
- When undefined: the port does not exist, and framing errors are silently discarded.

Test Plan:
- Idle line high, then frame LSB-first bits 1,0,1,1,1,1,0,0 with a stop of 1 (104160 ns/bit, start bit 104660 ns) → single 1-cycle `rxODEBRANE` pulse at about 989.5 µs; `rxData_o` = 8'h3D.
- After two extra idle bit periods, frame bits 0,1,0,0,0,0,0,0 with stop 1 → one pulse; `rxData_o` = 8'h02; 8'h3D held until then.
- 2 µs low glitch on an idle line → no strobe, `rxData_o` unchanged, FSM back in IDLE.
- Frame 8'hA5 with stop bit 0, line high 3 bit periods later → no strobe, `rxData_o` keeps its previous value; with ODBIORNIK_FRAME_ERR_EN, `rxFrameErr_o` pulses once. A following valid 8'h5A frame → strobe, `rxData_o` = 8'h5A.
- `rst_i` asserted 1 cycle during bit 4 of a frame → `rxData_o` = 8'h00, no strobe for that frame; the next full frame 8'hFF decodes correctly.
- Two back-to-back frames 8'h00 and 8'hFF, each with one stop bit → two strobes about 10 bit periods apart, with the correct bytes.

Source files
------------

// File: rtl/odbiornik_uart.sv
// odbiornik_uart: 8N1 UART receiver with mid-bit sampling; ODBIORNIK_FRAME_ERR_EN adds rxFrameErr_o
module odbiornik_uart #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       RXD_i,
    output logic       rxODEBRANE,
`ifdef ODBIORNIK_FRAME_ERR_EN
    output logic       rxFrameErr_o,
`endif
    output logic [7:0] rxData_o
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    logic [1:0]    sync_q   = 2'b11;
    logic [2:0]    state_q  = IDLE,  state_d;
    logic [TW-1:0] timer_q  = '0,    timer_d;
    logic [2:0]    idx_q    = '0,    idx_d;
    logic [7:0]    shift_q  = '0,    shift_d;
    logic [7:0]    data_q   = '0,    data_d;
    logic          strobe_q = 1'b0,  strobe_d;
`ifdef ODBIORNIK_FRAME_ERR_EN
    logic          ferr_q   = 1'b0,  ferr_d;
    assign rxFrameErr_o = ferr_q;
`endif
    logic rxd_s;

    assign rxd_s      = sync_q[1];
    assign rxODEBRANE = strobe_q;
    assign rxData_o   = data_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        strobe_d = 1'b0;
`ifdef ODBIORNIK_FRAME_ERR_EN
        ferr_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                state_d = rxd_s ? IDLE : START;
            end
            START: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    state_d = (idx_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == BIT_LAST) begin
                    timer_d  = '0;
                    state_d  = rxd_s ? IDLE : WAIT_IDLE;
                    strobe_d = rxd_s;
                    data_d   = rxd_s ? shift_q : data_q;
`ifdef ODBIORNIK_FRAME_ERR_EN
                    ferr_d   = !rxd_s;
`endif
                end
            end
            WAIT_IDLE: state_d = rxd_s ? IDLE : WAIT_IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= 2'b11;
            state_q  <= IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
`ifdef ODBIORNIK_FRAME_ERR_EN
            ferr_q   <= 1'b0;
`endif
        end else begin
            sync_q   <= {sync_q[0], RXD_i};
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
`ifdef ODBIORNIK_FRAME_ERR_EN
            ferr_q   <= ferr_d;
`endif
        end
    end
endmodule

// File: tb/tb_odbiornik_uart.sv
// tb_odbiornik_uart: table-driven frames plus hand-written glitch, reset and back-to-back sequences
module tb_odbiornik_uart;
    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         ext;
        int         idle;
        logic       exp_strobe;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       strobe;
    logic [7:0] rx_data;
`ifdef ODBIORNIK_FRAME_ERR_EN
    logic       ferr;
    int         n_ferr = 0;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int strobe_cyc = 0;
    int strobe_cyc_prev = 0;
    int n_strobes = 0;
    int n0;
    logic prev_strobe = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] expv;
    vec_t vecs[4];

    odbiornik_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .RXD_i(rxd),
        .rxODEBRANE(strobe),
`ifdef ODBIORNIK_FRAME_ERR_EN
        .rxFrameErr_o(ferr),
`endif
        .rxData_o(rx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (strobe) begin
            strobe_cyc_prev = strobe_cyc;
            strobe_cyc = cyc;
            n_strobes++;
            chk("strobe_width", {31'd0, prev_strobe}, 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe got=%0h exp=none", rx_data);
            end else begin
                expv = exp_q.pop_front();
                chk("byte", {24'd0, rx_data}, {24'd0, expv});
            end
        end
        prev_strobe = strobe;
`ifdef ODBIORNIK_FRAME_ERR_EN
        if (ferr) n_ferr++;
`endif
    end

    // caller must be at a negedge; returns at a negedge with the line idle
    task automatic send(input logic [7:0] d, input logic stop, input int ext);
        rxd = 1'b0;
        fall_cyc = cyc;
        repeat (CPB + ext) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    initial begin
        vecs[0] = '{data: 8'h3D, stop: 1'b1, ext: 3, idle: 3 * CPB, exp_strobe: 1'b1, exp_data: 8'h3D};
        vecs[1] = '{data: 8'h02, stop: 1'b1, ext: 0, idle: 3 * CPB, exp_strobe: 1'b1, exp_data: 8'h02};
        vecs[2] = '{data: 8'hA5, stop: 1'b0, ext: 0, idle: 3 * CPB, exp_strobe: 1'b0, exp_data: 8'h02};
        vecs[3] = '{data: 8'h5A, stop: 1'b1, ext: 0, idle: 3 * CPB, exp_strobe: 1'b1, exp_data: 8'h5A};

        repeat (4) @(negedge clk);
        chk("reset_data", {24'd0, rx_data}, 0);
        chk("reset_strobe", {31'd0, strobe}, 0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            n0 = n_strobes;
            if (vecs[i].exp_strobe) exp_q.push_back(vecs[i].data);
            send(vecs[i].data, vecs[i].stop, vecs[i].ext);
            repeat (vecs[i].idle) @(negedge clk);
            chk("strobe_count", n_strobes - n0, {31'd0, vecs[i].exp_strobe});
            chk("held_data", {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
            if (vecs[i].exp_strobe)
                chk("latency", {31'd0, (strobe_cyc - fall_cyc) inside {[152:158]}}, 1);
            if (i == 1) begin
                // short low glitch must be rejected at the start-bit midpoint
                n0 = n_strobes;
                rxd = 1'b0;
                repeat (3) @(negedge clk);
                rxd = 1'b1;
                repeat (2 * CPB) @(negedge clk);
                chk("glitch_strobe", n_strobes - n0, 0);
                chk("glitch_held", {24'd0, rx_data}, 8'h02);
            end
        end

        n0 = n_strobes;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rxd = 1'b1;
        chk("midreset_data", {24'd0, rx_data}, 0);
        repeat (12 * CPB) @(negedge clk);
        chk("midreset_strobe", n_strobes - n0, 0);
        chk("midreset_held", {24'd0, rx_data}, 0);

        exp_q.push_back(8'hFF);
        send(8'hFF, 1'b1, 0);
        repeat (2 * CPB) @(negedge clk);
        chk("after_reset_data", {24'd0, rx_data}, 8'hFF);

        n0 = n_strobes;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send(8'h00, 1'b1, 0);
        send(8'hFF, 1'b1, 0);
        repeat (3 * CPB) @(negedge clk);
        chk("b2b_count", n_strobes - n0, 2);
        chk("b2b_spacing", strobe_cyc - strobe_cyc_prev, 10 * CPB);
        chk("b2b_data", {24'd0, rx_data}, 8'hFF);
        chk("queue_empty", exp_q.size(), 0);
`ifdef ODBIORNIK_FRAME_ERR_EN
        chk("ferr_count", n_ferr, 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
